// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: FSM state encoding and requester count.
package bram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ARB,
    LOCK0,
    LOCK1
  } arb_state_t;

endpackage

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one registered-read BRAM port, with lock support for atomics.
// Define BRAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int WADDR = 10,
  parameter int WDATA = 32
) (
  input  logic             pi_clk,
  input  logic             pi_rst_n,
  input  logic             pi_req0,
  input  logic             pi_req1,
  input  logic             pi_we0,
  input  logic             pi_we1,
  input  logic             pi_lock0,
  input  logic             pi_lock1,
  input  logic [WADDR-1:0] pi_addr0,
  input  logic [WADDR-1:0] pi_addr1,
  input  logic [WDATA-1:0] pi_wdata0,
  input  logic [WDATA-1:0] pi_wdata1,
  output logic             po_gnt0,
  output logic             po_gnt1,
  output logic             po_rvalid0,
  output logic             po_rvalid1,
  output logic [WDATA-1:0] po_rdata0,
  output logic [WDATA-1:0] po_rdata1,
  output logic             po_en,
  output logic             po_we,
  output logic [WADDR-1:0] po_addr,
  output logic [WDATA-1:0] po_di,
  input  logic [WDATA-1:0] pi_do
);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rvalid_q;
  logic               sel_lock;
`ifdef BRAM_ARB_RR_EN
  logic               ptr_q;
`endif

  assign req = {pi_req1, pi_req0};

  // Grant is forced low while reset is asserted so nothing reaches the BRAM.
  always_comb begin
    gnt = '0;
    if (pi_rst_n) begin
      case (state_q)
        LOCK0:   gnt[0] = req[0];
        LOCK1:   gnt[1] = req[1];
        default: begin
          if (req[0] && req[1]) begin
`ifdef BRAM_ARB_RR_EN
            gnt[ptr_q] = 1'b1;
`else
            gnt[0] = 1'b1;
`endif
          end else begin
            gnt = req;
          end
        end
      endcase
    end
  end

  assign po_gnt0 = gnt[0];
  assign po_gnt1 = gnt[1];

  always_comb begin
    po_en    = 1'b0;
    po_we    = 1'b0;
    po_addr  = '0;
    po_di    = '0;
    sel_lock = 1'b0;
    if (gnt[1]) begin
      po_en    = 1'b1;
      po_we    = pi_we1;
      po_addr  = pi_addr1;
      po_di    = pi_wdata1;
      sel_lock = pi_lock1;
    end else if (gnt[0]) begin
      po_en    = 1'b1;
      po_we    = pi_we0;
      po_addr  = pi_addr0;
      po_di    = pi_wdata0;
      sel_lock = pi_lock0;
    end
  end

  // Lock state, arbitration pointer and the one-cycle read response tag.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      state_q  <= ARB;
      rvalid_q <= '0;
`ifdef BRAM_ARB_RR_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      rvalid_q <= gnt & {~pi_we1, ~pi_we0};
`ifdef BRAM_ARB_RR_EN
      if (po_en) ptr_q <= gnt[0];
`endif
      case (state_q)
        ARB: begin
          if (po_en && sel_lock) state_q <= gnt[1] ? LOCK1 : LOCK0;
        end
        LOCK0: begin
          if (!pi_lock0 && (gnt[0] || !pi_req0)) state_q <= ARB;
        end
        LOCK1: begin
          if (!pi_lock1 && (gnt[1] || !pi_req1)) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign po_rvalid0 = rvalid_q[0];
  assign po_rvalid1 = rvalid_q[1];
  assign po_rdata0  = pi_do;
  assign po_rdata1  = pi_do;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: transaction-level model plus directed literal checks.
// Honours BRAM_ARB_RR_EN the same way as the design.
module tb_bram_port_arbiter;

  localparam int WADDR = 10;
  localparam int WDATA = 32;

  logic             clk;
  logic             rst_n;
  logic             req0, req1, we0, we1, lock0, lock1;
  logic [WADDR-1:0] addr0, addr1;
  logic [WDATA-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, rvalid0, rvalid1;
  logic [WDATA-1:0] rdata0, rdata1;
  logic             po_en, po_we;
  logic [WADDR-1:0] po_addr;
  logic [WDATA-1:0] po_di;
  logic [WDATA-1:0] bram_do;

  int errors = 0;
  int checks = 0;

  bram_port_arbiter #(.WADDR(WADDR), .WDATA(WDATA)) dut (
    .pi_clk(clk), .pi_rst_n(rst_n),
    .pi_req0(req0), .pi_req1(req1),
    .pi_we0(we0), .pi_we1(we1),
    .pi_lock0(lock0), .pi_lock1(lock1),
    .pi_addr0(addr0), .pi_addr1(addr1),
    .pi_wdata0(wdata0), .pi_wdata1(wdata1),
    .po_gnt0(gnt0), .po_gnt1(gnt1),
    .po_rvalid0(rvalid0), .po_rvalid1(rvalid1),
    .po_rdata0(rdata0), .po_rdata1(rdata1),
    .po_en(po_en), .po_we(po_we), .po_addr(po_addr), .po_di(po_di),
    .pi_do(bram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment BRAM with registered read output.
  logic [WDATA-1:0] bram [0:(1<<WADDR)-1];
  always @(posedge clk) begin
    if (po_en) begin
      if (po_we) bram[po_addr] <= po_di;
      else       bram_do <= bram[po_addr];
    end
  end

  // Reference model state: memory contents, lock owner, pointer, pending response.
  logic [WDATA-1:0] ref_mem [0:(1<<WADDR)-1];
  int               own = -1;
  int               ptr = 0;
  logic             pend_v = 1'b0;
  int               pend_id = 0;
  logic [WDATA-1:0] pend_data = '0;
  int               g;
  logic [1:0]       m_req, m_we, m_lock;
  logic [WADDR-1:0] m_addr [2];
  logic [WDATA-1:0] m_wdata [2];

  initial begin
    for (int i = 0; i < (1 << WADDR); i++) begin
      bram[i]    = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    bram[5] = 32'hDEAD_BEEF; ref_mem[5] = 32'hDEAD_BEEF;
    bram[1] = 32'h1111_1111; ref_mem[1] = 32'h1111_1111;
    bram[2] = 32'h2222_2222; ref_mem[2] = 32'h2222_2222;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin : compare_proc
    if (!rst_n) begin
      checkOutput("rst_gnt0", gnt0, 0);
      checkOutput("rst_gnt1", gnt1, 0);
      checkOutput("rst_en", po_en, 0);
      checkOutput("rst_rvalid0", rvalid0, 0);
      checkOutput("rst_rvalid1", rvalid1, 0);
      own = -1; ptr = 0; pend_v = 1'b0;
    end else begin
      checkOutput("m_rvalid0", rvalid0, pend_v && pend_id == 0);
      checkOutput("m_rvalid1", rvalid1, pend_v && pend_id == 1);
      if (pend_v) checkOutput("m_rdata", pend_id == 0 ? rdata0 : rdata1, pend_data);

      m_req = {req1, req0}; m_we = {we1, we0}; m_lock = {lock1, lock0};
      m_addr[0] = addr0; m_addr[1] = addr1;
      m_wdata[0] = wdata0; m_wdata[1] = wdata1;

      if (own >= 0)                 g = m_req[own] ? own : -1;
`ifdef BRAM_ARB_RR_EN
      else if (m_req == 2'b11)      g = ptr;
`else
      else if (m_req == 2'b11)      g = 0;
`endif
      else if (m_req[0])            g = 0;
      else if (m_req[1])            g = 1;
      else                          g = -1;

      checkOutput("m_gnt0", gnt0, g == 0);
      checkOutput("m_gnt1", gnt1, g == 1);
      checkOutput("m_en", po_en, g >= 0);
      checkOutput("m_we", po_we, g >= 0 ? m_we[g] : 1'b0);
      checkOutput("m_addr", po_addr, g >= 0 ? m_addr[g] : '0);
      checkOutput("m_di", po_di, g >= 0 ? m_wdata[g] : '0);

      pend_v = 1'b0;
      if (g >= 0) begin
        if (m_we[g]) ref_mem[m_addr[g]] = m_wdata[g];
        else begin
          pend_v = 1'b1; pend_id = g; pend_data = ref_mem[m_addr[g]];
        end
        ptr = 1 - g;
        own = m_lock[g] ? g : -1;
      end else if (own >= 0 && !m_req[own] && !m_lock[own]) begin
        own = -1;
      end
    end
  end

  task automatic applyStimulus(
    input logic r0, input logic w0, input logic l0, input logic [WADDR-1:0] a0, input logic [WDATA-1:0] d0,
    input logic r1, input logic w1, input logic l1, input logic [WADDR-1:0] a1, input logic [WDATA-1:0] d1);
    @(posedge clk);
    #1;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 0; lock0 = 0; addr0 = 10'h005; wdata0 = '0;
    req1 = 1'b1; we1 = 0; lock1 = 0; addr1 = 10'h001; wdata1 = '0;
    #3;
    checkOutput("reset_gnt_forced0", gnt0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    req0 = 0; req1 = 0;

    // Single read from requester 0.
    applyStimulus(1, 0, 0, 10'h005, '0, 0, 0, 0, '0, '0);
    #2;
    checkOutput("t1_gnt0", gnt0, 1);
    checkOutput("t1_gnt1", gnt1, 0);
    checkOutput("t1_en", po_en, 1);
    checkOutput("t1_addr", po_addr, 10'h005);
    idle();
    #2;
    checkOutput("t1_rvalid0", rvalid0, 1);
    checkOutput("t1_rdata0", rdata0, 32'hDEAD_BEEF);
    checkOutput("t1_rvalid1", rvalid1, 0);

    // Requester 1 alone so the pointer favours requester 0 next.
    applyStimulus(0, 0, 0, '0, '0, 1, 0, 0, 10'h007, '0);

    // Both requesting for four cycles.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 10'h001, '0, 1, 0, 0, 10'h002, '0);
      #2;
`ifdef BRAM_ARB_RR_EN
      checkOutput("t2_rr_gnt0", gnt0, (k % 2) == 0);
      checkOutput("t2_rr_gnt1", gnt1, (k % 2) == 1);
`else
      checkOutput("t2_fix_gnt0", gnt0, 1);
      checkOutput("t2_fix_gnt1", gnt1, 0);
`endif
      if (k == 1) begin
        checkOutput("t2_rvalid0", rvalid0, 1);
        checkOutput("t2_rdata0", rdata0, 32'h1111_1111);
      end
    end
    idle();

    // Locked write then read by requester 1 while requester 0 waits.
    applyStimulus(0, 0, 0, '0, '0, 1, 1, 1, 10'h010, 32'h1234_5678);
    #2;
    checkOutput("t3_gnt1_wr", gnt1, 1);
    applyStimulus(1, 0, 0, 10'h003, '0, 1, 0, 0, 10'h010, '0);
    #2;
    checkOutput("t3_gnt0_locked", gnt0, 0);
    checkOutput("t3_gnt1_rd", gnt1, 1);
    applyStimulus(1, 0, 0, 10'h003, '0, 0, 0, 0, '0, '0);
    #2;
    checkOutput("t3_gnt0_after", gnt0, 1);
    checkOutput("t3_rvalid1", rvalid1, 1);
    checkOutput("t3_rdata1", rdata1, 32'h1234_5678);
    idle();

    // Lock released by dropping req and lock together.
    applyStimulus(0, 0, 0, '0, '0, 1, 0, 1, 10'h004, '0);
    #2;
    checkOutput("t4_gnt1", gnt1, 1);
    applyStimulus(1, 0, 0, 10'h009, '0, 0, 0, 0, '0, '0);
    #2;
    checkOutput("t4_gnt0_blocked", gnt0, 0);
    applyStimulus(1, 0, 0, 10'h009, '0, 0, 0, 0, '0, '0);
    #2;
    checkOutput("t4_gnt0_free", gnt0, 1);
    idle();

    // Reset while locked with a read pending.
    applyStimulus(1, 0, 1, 10'h006, '0, 0, 0, 0, '0, '0);
    #2;
    checkOutput("t5_gnt0", gnt0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    addr0 = 10'h008;
    #2;
    checkOutput("t5_rvalid0_dropped", rvalid0, 0);
    checkOutput("t5_gnt0_in_reset", gnt0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0 = 0; lock0 = 1;
    req1 = 1; we1 = 0; lock1 = 0; addr1 = 10'h00B;
    #2;
    checkOutput("t5_gnt1_after_reset", gnt1, 1);

    // Compact directed mix checked by the model.
    for (int i = 0; i < 48; i++) begin
      applyStimulus((i % 3) != 0, (i % 6) == 2, (i % 5) == 1, WADDR'(i % 16), WDATA'(i * 32'h0101_0101),
                    (i % 4) < 2,  (i % 5) == 4, (i % 7) == 3, WADDR'((i + 3) % 16), WDATA'(i * 32'h1001_0001));
    end
    idle();
    idle();
    idle();
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter sharing a single BRAM port (WADDR/WDATA, one-cycle registered read) between requesters, e.g. instruction fetch (requester 0) and load/store/AMO unit (requester 1) of the RV32IMA core. It issues at most one access per cycle and routes read data back with a one-cycle tagged response. A lock mechanism lets the holder keep the port across consecutive accesses for atomic read-modify-write.

## Interface
Parameters:
- WADDR, 10, BRAM address width
- WDATA, 32, BRAM data width

Ports:
- pi_clk  in  1  clock, shared with the BRAM port
- pi_rst_n  in  1  asynchronous active-low reset
- pi_req0 / pi_req1  in  1  access request
- pi_we0 / pi_we1  in  1  1 = write, 0 = read
- pi_lock0 / pi_lock1  in  1  keep the port after this access
- pi_addr0 / pi_addr1  in  WADDR  access address
- pi_wdata0 / pi_wdata1  in  WDATA  write data
- po_gnt0 / po_gnt1  out  1  request accepted this cycle
- po_rvalid0 / po_rvalid1  out  1  read data valid, one cycle
- po_rdata0 / po_rdata1  out  WDATA  read data, qualified by rvalid
- po_en, po_we  out  1  BRAM enable / write enable
- po_addr  out  WADDR  BRAM address
- po_di  out  WDATA  BRAM write data
- pi_do  in  WDATA  BRAM read data (registered in BRAM)

## Operation
- Transfer on requester N when pi_reqN && po_gntN; at most one gnt per cycle.
- BRAM drive is combinational from the granted requester: po_en=1, po_we/po_addr/po_di = pi_weN/pi_addrN/pi_wdataN. With no grant, po_en=0, po_we=0, po_addr=0, po_di=0.
- FSM states ARB, LOCK0, LOCK1; reset state ARB.
- ARB: a single requester wins; if both request, requester ptr wins. Accepted transfer with pi_lockN=1 goes to LOCKN.
- LOCKN: only N may be granted (po_gntN = pi_reqN); the other gnt is 0 even when N is idle. Exit to ARB on an accepted transfer from N with pi_lockN=0, or when pi_reqN=0 && pi_lockN=0 (no transfer).
- ptr (1 bit, reset 0): after any accepted transfer ptr = other requester; unchanged otherwise.
- Reads: accepted read registers tag (valid, id). Next cycle po_rvalid[id]=1, po_rdata[id]=pi_do. po_rdataN carries pi_do continuously and is only meaningful with rvalid.
- Writes: complete on accept, no response; BRAM output during writes ignored.
- Throughput one access per cycle; response of a previous read and a new grant coexist in the same cycle.
- Reset values: po_gnt*=0 (no req while in reset is not required, gnt forced 0 during reset), po_rvalid*=0, state ARB, ptr 0, tag invalid. Reset mid-lock returns to ARB; a pending response is dropped.

## Timing
- Grant and BRAM drive: combinational, same cycle as request; requesters must not make pi_req depend on po_gnt.
- Read latency: exactly 1 cycle from accept to po_rvalid.
- Lock entry/exit and ptr update take effect the cycle after the deciding transfer.
- Address/data must be stable while pi_req is high and gnt low.

## Configuration
- BRAM_ARB_RR_EN defined: round-robin via ptr as above.
- Undefined: fixed priority, requester 0 wins in ARB; ptr not implemented. Lock behaviour identical.

## Structure
- Package bram_arb_pkg: enum arb_state_t {ARB, LOCK0, LOCK1}, localparam NUM_REQ = 2.
- No sub-module; BRAM instantiated by the parent next to the arbiter.

## Test plan
- Only req0 reads addr 0x005 (mem 0xDEADBEEF) -> gnt0 same cycle, po_en=1, po_addr=0x005; next cycle rvalid0=1, rdata0=0xDEADBEEF, rvalid1=0.
- Both req, reads 0x001/0x002 held 4 cycles (RR_EN) -> grants 0,1,0,1; rvalid alternates one cycle later with correct data.
- Same without RR_EN -> gnt0 every cycle, gnt1 never while req0 high.
- req1 write 0x010=0x12345678 lock=1, then read 0x010 lock=0, req0 asserted throughout -> gnt0=0 both cycles, rdata1=0x12345678, req0 granted cycle after unlock.
- LOCK1 entered, req1=lock1=0 next cycle -> ARB, no transfer, req0 granted following cycle.
- pi_rst_n low during LOCK0 with read pending -> rvalid0=0, state ARB, ptr 0; after release req1 alone is granted.
